// File: rtl/glbl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : glbl_pkg
//  Description : Shared types and constants for the global control block:
//                FSM state encoding, default success code and a counter
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package glbl_pkg;

    // Top-level sequencing states, from power-on pulses to terminal verdict
    typedef enum logic [2:0] {
        ST_GSR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ARMED = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Debug word the core writes when its self-test succeeds
    localparam logic [31:0] SUCCESS_CODE_DEFAULT = 32'hDEADBEEF;

    // Bits needed to hold 0..limit, never less than one
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/glbl_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : glbl_pulse_gen
//  Description : Post-reset pulse generator. The output is high out of reset
//                and stays high for CYCLES rising edges, then drops for good.
//                expire_o flags (combinationally) the edge on which the pulse
//                is about to drop or has already dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module glbl_pulse_gen
    import glbl_pkg::*;
#(
    parameter int unsigned CYCLES = 10
) (
    input  logic clk,
    input  logic reset_n,
    output logic pulse_o,
    output logic expire_o
);

    localparam int unsigned      c_w     = cnt_width(CYCLES);
    localparam logic [c_w-1:0]   c_limit = c_w'(CYCLES);
    localparam logic [c_w-1:0]   c_one   = c_w'(1);

    logic [c_w-1:0] cnt_q;
    logic [c_w-1:0] cnt_d;
    logic           pulse_q;
    logic           pulse_d;

    // Elapsed-cycle counter saturates at the limit; pulse holds until then
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q < c_limit) begin
            cnt_d = cnt_q + c_one;
        end
        pulse_d = (cnt_d < c_limit);
    end

    // Counter and pulse registers; pulse is asserted while in reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            pulse_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o  = pulse_q;
    assign expire_o = ~pulse_d;

endmodule
`default_nettype wire

// File: rtl/glbl_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : glbl_ctrl
//  Description : Global control for the riscv32i core and its wrapper.
//                Sequences GSR/GTS pulses after reset, holds the core in
//                reset through an idle window, runs it while start_i is high
//                and reports a sticky pass or timeout verdict. Also provides
//                a free-running cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module glbl_ctrl
    import glbl_pkg::*;
#(
    parameter int unsigned ROC_CYCLES     = 10,
    parameter int unsigned TOC_CYCLES     = 10,
    parameter int unsigned IDLE_LEN       = 10,
    parameter logic [31:0] SUCCESS_CODE   = SUCCESS_CODE_DEFAULT,
    parameter int unsigned SUCCESS_HOLD   = 30,
    parameter int unsigned TIMEOUT_CYCLES = 1100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [31:0] final_value_i,
    output logic        gsr_o,
    output logic        gts_o,
    output logic        core_reset_o,
    output logic        run_o,
    output logic [31:0] cycle_count_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic        done_o
);

    localparam int unsigned        c_idle_w  = cnt_width(IDLE_LEN);
    localparam int unsigned        c_run_w   = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned        c_succ_w  = cnt_width(SUCCESS_HOLD);
    localparam logic [c_idle_w-1:0] c_idle_len = c_idle_w'(IDLE_LEN);
    localparam logic [c_idle_w-1:0] c_idle_one = c_idle_w'(1);
    localparam logic [c_run_w-1:0]  c_timeout  = c_run_w'(TIMEOUT_CYCLES);
    localparam logic [c_run_w-1:0]  c_run_one  = c_run_w'(1);
    localparam logic [c_succ_w-1:0] c_hold     = c_succ_w'(SUCCESS_HOLD);
    localparam logic [c_succ_w-1:0] c_succ_one = c_succ_w'(1);

    state_e                state_q;
    state_e                state_d;
    logic [c_idle_w-1:0]   idle_q;
    logic [c_idle_w-1:0]   idle_d;
    logic [c_run_w-1:0]    run_cnt_q;
    logic [c_run_w-1:0]    run_cnt_d;
    logic [c_succ_w-1:0]   succ_q;
    logic [c_succ_w-1:0]   succ_d;
    logic                  pass_q;
    logic                  pass_d;
    logic                  timeout_q;
    logic                  timeout_d;
    logic                  run_q;
    logic                  run_d;
    logic                  core_reset_q;
    logic                  core_reset_d;
    logic [31:0]           cycle_q;
    logic [31:0]           cycle_d;

    logic                  w_gsr_expire;
    logic                  w_gts_expire;
    logic                  w_hit;

    glbl_pulse_gen #(
        .CYCLES   (ROC_CYCLES)
    ) u_gsr_pulse (
        .clk      (clk),
        .reset_n  (reset_n),
        .pulse_o  (gsr_o),
        .expire_o (w_gsr_expire)
    );

    glbl_pulse_gen #(
        .CYCLES   (TOC_CYCLES)
    ) u_gts_pulse (
        .clk      (clk),
        .reset_n  (reset_n),
        .pulse_o  (gts_o),
        .expire_o (w_gts_expire)
    );

    assign w_hit = (final_value_i == SUCCESS_CODE);

    // Next-state logic: sequencing, idle window, run/success/timeout counting
    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        run_cnt_d = run_cnt_q;
        succ_d    = succ_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_GSR: begin
                // Leave on the same edge the later of the two pulses drops
                if (w_gsr_expire && w_gts_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                idle_d = idle_q + c_idle_one;
                if (idle_d >= c_idle_len) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // start_i low pauses the run: every counter holds
                if (start_i) begin
                    if (run_cnt_q != c_timeout) begin
                        run_cnt_d = run_cnt_q + c_run_one;
                    end
                    if (w_hit && (succ_q != c_hold)) begin
                        succ_d = succ_q + c_succ_one;
                    end
                    // Pass is tested first so it wins a same-edge tie
                    if (succ_d == c_hold) begin
                        pass_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (run_cnt_d == c_timeout) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_GSR;
            end
        endcase
    end

    assign core_reset_d = (state_d == ST_GSR);
    assign run_d        = (state_d == ST_RUN) && start_i;
    assign cycle_d      = cycle_q + 32'd1;

    // State, counter and registered-output flops with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_GSR;
            idle_q       <= '0;
            run_cnt_q    <= '0;
            succ_q       <= '0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            run_q        <= 1'b0;
            core_reset_q <= 1'b1;
            cycle_q      <= '0;
        end else begin
            state_q      <= state_d;
            idle_q       <= idle_d;
            run_cnt_q    <= run_cnt_d;
            succ_q       <= succ_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            run_q        <= run_d;
            core_reset_q <= core_reset_d;
            cycle_q      <= cycle_d;
        end
    end

    assign core_reset_o  = core_reset_q;
    assign run_o         = run_q;
    assign pass_o        = pass_q;
    assign timeout_o     = timeout_q;
    assign done_o        = pass_q | timeout_q;
    assign cycle_count_o = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_glbl_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_glbl_ctrl
//  Description : Self-checking bench for glbl_ctrl. A cycle-level reference
//                model derived from edge counts after reset is compared with
//                the DUT after every edge; a vector table and hand sequences
//                cover the pass, timeout, tie, pause and mid-run reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_glbl_ctrl;

    localparam int          ROC   = 10;
    localparam int          TOC   = 10;
    localparam int          IDLE  = 10;
    localparam int          HOLD  = 30;
    localparam int          TMO   = 1100;
    localparam logic [31:0] CODE  = 32'hDEADBEEF;
    localparam int          MAXTC = (ROC > TOC) ? ROC : TOC;
    localparam int          ARMED_EDGE = MAXTC + IDLE;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic [31:0] fv      = 32'h0;

    logic        gsr_o;
    logic        gts_o;
    logic        core_reset_o;
    logic        run_o;
    logic [31:0] cycle_count_o;
    logic        pass_o;
    logic        timeout_o;
    logic        done_o;

    glbl_ctrl #(
        .ROC_CYCLES     (ROC),
        .TOC_CYCLES     (TOC),
        .IDLE_LEN       (IDLE),
        .SUCCESS_CODE   (CODE),
        .SUCCESS_HOLD   (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_i       (start),
        .final_value_i (fv),
        .gsr_o         (gsr_o),
        .gts_o         (gts_o),
        .core_reset_o  (core_reset_o),
        .run_o         (run_o),
        .cycle_count_o (cycle_count_o),
        .pass_o        (pass_o),
        .timeout_o     (timeout_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: edges since reset release and run statistics
    int          m_k;
    bit          m_started;
    bit          m_pass;
    bit          m_tmo;
    bit          m_run;
    int          m_active;
    int          m_hits;
    logic [31:0] m_cyc;

    typedef struct packed {
        logic        start;
        logic [31:0] fv;
        logic [15:0] n;
        logic [6:0]  exp;   // {gsr, gts, core_reset, run, pass, timeout, done}
    } vec_t;

    vec_t tbl [7];

    task automatic model_reset();
        m_k       = 0;
        m_started = 1'b0;
        m_pass    = 1'b0;
        m_tmo     = 1'b0;
        m_run     = 1'b0;
        m_active  = 0;
        m_hits    = 0;
        m_cyc     = 32'h0;
    endtask

    task automatic model_edge();
        if (reset_n) begin
            m_k++;
            m_cyc = m_cyc + 32'd1;
            if (m_pass || m_tmo) begin
                m_run = 1'b0;
            end else if (!m_started) begin
                if ((m_k > ARMED_EDGE) && start) begin
                    m_started = 1'b1;
                    m_run     = 1'b1;
                end
            end else begin
                if (start) begin
                    m_active++;
                    if (fv == CODE) m_hits++;
                    if (m_hits >= HOLD)       m_pass = 1'b1;
                    else if (m_active >= TMO) m_tmo  = 1'b1;
                end
                m_run = start && !(m_pass || m_tmo);
            end
        end
    endtask

    function automatic logic [6:0] exp_flags();
        return {m_k < ROC, m_k < TOC, m_k < MAXTC, m_run, m_pass, m_tmo, m_pass | m_tmo};
    endfunction

    function automatic logic [6:0] act_flags();
        return {gsr_o, gts_o, core_reset_o, run_o, pass_o, timeout_o, done_o};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "/flags"},  64'(act_flags()),  64'(exp_flags()));
        check({tag, "/cycles"}, 64'(cycle_count_o), 64'(m_cyc));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    // Asynchronous assert between edges, three held cycles, release after an edge
    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_model("reset_async");
        check("reset_flags", 64'(act_flags()), 64'(7'b1110000));
        repeat (3) step("reset_hold");
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cum;
        tbl[0] = '{1'b1, 32'h0, 16'd9,  7'b1110000};
        tbl[1] = '{1'b1, 32'h0, 16'd1,  7'b0000000};
        tbl[2] = '{1'b1, 32'h0, 16'd10, 7'b0000000};
        tbl[3] = '{1'b1, 32'h0, 16'd1,  7'b0001000};
        tbl[4] = '{1'b1, CODE,  16'd29, 7'b0001000};
        tbl[5] = '{1'b1, CODE,  16'd1,  7'b0000101};
        tbl[6] = '{1'b0, 32'h0, 16'd5,  7'b0000101};

        #2;
        // Table: power-on sequence and a straight 30-hit pass
        do_reset();
        cum = 0;
        for (int i = 0; i < 7; i++) begin
            start = tbl[i].start;
            fv    = tbl[i].fv;
            repeat (int'(tbl[i].n)) step("table");
            cum += int'(tbl[i].n);
            check($sformatf("table[%0d]/flags", i), 64'(act_flags()), 64'(tbl[i].exp));
            check($sformatf("table[%0d]/cycles", i), 64'(cycle_count_o), 64'(cum));
        end

        // Timeout after exactly TMO run cycles with no success
        do_reset();
        start = 1'b1;
        fv    = 32'h0;
        repeat (21) step("tmo");
        check("tmo/run_rise", 64'(run_o), 64'(1));
        repeat (TMO - 1) step("tmo");
        check("tmo/not_yet", 64'(timeout_o), 64'(0));
        step("tmo");
        check("tmo/flags", 64'(act_flags()), 64'(7'b0000011));

        // Interleaved hits: 15 hits, 5 misses, 15 hits
        do_reset();
        start = 1'b1;
        fv    = 32'h0;
        repeat (21) step("ilv");
        fv = CODE;          repeat (15) step("ilv");
        fv = 32'h12345678;  repeat (5)  step("ilv");
        fv = CODE;          repeat (14) step("ilv");
        check("ilv/29_hits", 64'(pass_o), 64'(0));
        step("ilv");
        check("ilv/30th_hit", 64'(act_flags()), 64'(7'b0000101));

        // Pause: hits while start_i is low must not count
        do_reset();
        start = 1'b1;
        fv    = CODE;
        repeat (21) step("pause");
        repeat (10) step("pause");
        start = 1'b0;
        repeat (5) step("pause");
        check("pause/run_low", 64'(run_o), 64'(0));
        start = 1'b1;
        repeat (19) step("pause");
        check("pause/29_hits", 64'(pass_o), 64'(0));
        step("pause");
        check("pause/pass", 64'(pass_o), 64'(1));

        // Pass and timeout on the same edge: pass wins
        do_reset();
        start = 1'b1;
        fv    = 32'h0;
        repeat (21) step("tie");
        repeat (TMO - HOLD) step("tie");
        fv = CODE;
        repeat (HOLD) step("tie");
        check("tie/flags", 64'(act_flags()), 64'(7'b0000101));

        // Asynchronous reset mid-RUN, then the full sequence again
        do_reset();
        start = 1'b1;
        fv    = 32'h0;
        repeat (30) step("mid");
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid/async_flags", 64'(act_flags()), 64'(7'b1110000));
        check("mid/async_cycles", 64'(cycle_count_o), 64'(0));
        repeat (2) step("mid_hold");
        reset_n = 1'b1;
        repeat (20) step("mid_again");
        check("mid/run_not_yet", 64'(run_o), 64'(0));
        step("mid_again");
        check("mid/run_rise", 64'(run_o), 64'(1));

        // Randomized runs checked against the reference model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                start = ($urandom_range(0, 7) != 0);
                fv    = ($urandom_range(0, 3) != 0) ? CODE : 32'($urandom);
                step("rand");
                if ((r == 3) && (c == 40)) begin
                    #2;
                    reset_n = 1'b0;
                    model_reset();
                    #1;
                    check_model("rand_async");
                    step("rand_hold");
                    reset_n = 1'b1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
